dcache_access_ctrl: RTL and testbench
=====================================

// Module: dcache_access_ctrl
// PURPOSE
//  MEM-stage front end for the data cache. Takes load/store requests from the pipeline and presents them to Cache with a valid/ready handshake.
//  On a miss, latches the request, stalls the pipeline and re-issues it once the cache is ready again. Returns load data on completion.
//  Keeps saturating hit/miss/stall-cycle counters and a sticky timeout error flag.
// PARAMETERS
//  CNT_WIDTH  32    width of each performance counter
//  TIMEOUT    1024  max cycles spent waiting on one miss before mem_error is set
// PORTS
//  clk              in   1          clock; all state updates on posedge
//  reset            in   1          synchronous, active-high
//  mem_read         in   1          pipeline load request (MEM stage)
//  mem_write        in   1          pipeline store request; never asserted together with mem_read
//  addr             in   32         word-aligned byte address
//  din              in   32         store data
//  dout             out  32         load data; valid in the cycle stall=0 while a load completes
//  stall            out  1          freeze pipeline (PC and all stage registers)
//  mem_error        out  1          sticky: a single miss exceeded TIMEOUT cycles
//  c_is_input_valid out  1          -> Cache.is_input_valid
//  c_mem_rw         out  1          -> Cache.mem_rw (1 = write)
//  c_addr           out  32         -> Cache.addr
//  c_din            out  32         -> Cache.din
//  c_is_ready       in   1          <- Cache.is_ready
//  c_is_hit         in   1          <- Cache.is_hit
//  c_dout           in   32         <- Cache.dout
//  hit_count        out  CNT_WIDTH  requests completed without a miss
//  miss_count       out  CNT_WIDTH  requests that missed (counted once per request)
//  stall_cycles     out  CNT_WIDTH  cycles with stall=1
// BEHAVIOUR
//  Reset: state=S_IDLE; all counters=0; mem_error=0; latch regs=0; every output 0 except combinational pass-through.
//  req = mem_read | mem_write. A request is issued only while state=S_IDLE or S_RETRY and c_is_ready=1.
//  S_IDLE: c_addr/c_din/c_mem_rw come straight from pipeline; c_is_input_valid=req & c_is_ready.
//   - req & c_is_ready & c_is_hit: complete in the same cycle; stall=0; dout=c_dout; hit_count++. Cache commits store at this posedge.
//   - req & c_is_ready & !c_is_hit: stall=1; latch addr/din/rw; miss_count++; wait_cnt=0; -> S_MISS.
//   - req & !c_is_ready (cache busy): stall=1; stay in S_IDLE.
//   - !req: stall=0; no issue.
//  S_MISS: c_is_input_valid=0; cache ports driven from the latch. Holding addr stable is mandatory because Cache indexes its fill from addr.
//   - stall=1; wait_cnt++ (saturate).
//   - c_is_ready=1 -> S_RETRY.
//  S_RETRY: c_is_input_valid=1 from latch; stall=1 unless c_is_hit.
//   - hit: complete; stall=0; dout=c_dout; -> S_IDLE. No counter changes besides stall_cycles.
//   - !hit & c_is_ready: -> S_MISS. Re-miss; miss_count is NOT incremented again.
//  Timeout: wait_cnt reaching TIMEOUT sets mem_error=1 (sticky until reset). FSM keeps waiting; it does not abort.
//  stall_cycles increments on every cycle with stall=1. All counters saturate at 2^CNT_WIDTH-1 and do not wrap.
//  Latency: hit = 0 extra cycles (combinational completion). Miss = cache fill time + 1 (S_MISS->S_RETRY) cycles of stall.
//  Reset mid-miss: FSM returns to S_IDLE; latch is discarded. Cache is reset by the same signal, so no request is outstanding.
//  Pipeline inputs are ignored while state != S_IDLE; the pipeline is frozen by stall.
//  mem_read & mem_write together is illegal; the block treats it as a write.
// STRUCTURE
//  Shared defines file mem_ctrl_defs.v: S_IDLE=2'b00, S_MISS=2'b01, S_RETRY=2'b10 plus MEM_RW_READ/WRITE. Included alongside CLOG2.v.
//  Sub-module sat_counter #(WIDTH): inputs clk, reset, inc; output count. Instantiated three times for hit/miss/stall counters.
//  The wait counter is local and uses CLOG2(TIMEOUT)+1 bits.
// TESTING
//  1 Cold load addr=0x100, cache model misses then is_ready after 50 cycles -> stall high 51 cycles, dout=mem[0x100]; miss_count=1, hit_count=0.
//  2 Load 0x104 right after test 1 (same line) -> stall=0 same cycle, dout correct; hit_count=1.
//  3 Store 0xDEADBEEF to 0x200 (miss), then load 0x200 -> load returns 0xDEADBEEF; miss_count=2, one hit for the load.
//  4 During S_MISS, toggle pipeline addr/din every cycle -> c_addr/c_din stay at the latched values; filled line matches the original addr.
//  5 Cache model never raises is_ready (TIMEOUT=16) -> mem_error=1 at wait cycle 16 and stays 1; stall remains 1.
//  6 Assert reset during S_MISS -> next cycle stall=0, counters=0, mem_error=0; a fresh load then completes correctly.

Source files
------------

// File: rtl/dcache_access_ctrl_pkg.sv
// Shared FSM encodings, cache direction codes and a width helper for the
// data-cache access controller.
package dcache_access_ctrl_pkg;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_MISS  = 2'b01;
    localparam logic [1:0] S_RETRY = 2'b10;

    localparam logic MEM_RW_READ  = 1'b0;
    localparam logic MEM_RW_WRITE = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dcache_access_ctrl_sat_counter.sv
// Saturating up-counter used for the hit, miss and stall-cycle statistics.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dcache_access_ctrl.sv
// MEM-stage front end for the data cache: issues pipeline loads/stores, holds
// a missed request stable until the fill completes, then re-issues it.
module dcache_access_ctrl
    import dcache_access_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [31:0]          addr,
    input  logic [31:0]          din,
    output logic [31:0]          dout,
    output logic                 stall,
    output logic                 mem_error,
    output logic                 c_is_input_valid,
    output logic                 c_mem_rw,
    output logic [31:0]          c_addr,
    output logic [31:0]          c_din,
    input  logic                 c_is_ready,
    input  logic                 c_is_hit,
    input  logic [31:0]          c_dout,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    localparam int WAIT_W = clog2(TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    // Handshake: a request transfers to the cache in a cycle where
    // c_is_input_valid=1 and c_is_ready=1; c_is_hit is meaningful only then.
    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_din;
    logic              lat_rw;
    logic [WAIT_W-1:0] wait_cnt;
    logic              req;
    logic              req_rw;
    logic              issue_hit;
    logic              issue_miss;
    logic              complete;

    assign req    = mem_read | mem_write;
    assign req_rw = mem_write ? MEM_RW_WRITE : MEM_RW_READ;

    always_comb begin
        state_next       = state;
        c_is_input_valid = 1'b0;
        c_mem_rw         = lat_rw;
        c_addr           = lat_addr;
        c_din            = lat_din;
        stall            = 1'b1;
        issue_hit        = 1'b0;
        issue_miss       = 1'b0;
        complete         = 1'b0;
        case (state)
            S_IDLE: begin
                c_mem_rw         = req_rw;
                c_addr           = addr;
                c_din            = din;
                c_is_input_valid = req & c_is_ready;
                issue_hit        = req & c_is_ready & c_is_hit;
                issue_miss       = req & c_is_ready & ~c_is_hit;
                complete         = issue_hit;
                stall            = req & ~issue_hit;
                if (issue_miss) begin
                    state_next = S_MISS;
                end
            end
            S_MISS: begin
                if (c_is_ready) begin
                    state_next = S_RETRY;
                end
            end
            S_RETRY: begin
                c_is_input_valid = 1'b1;
                if (c_is_hit) begin
                    complete   = 1'b1;
                    stall      = 1'b0;
                    state_next = S_IDLE;
                end else if (c_is_ready) begin
                    state_next = S_MISS;
                end
            end
            default: begin
                stall      = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    assign dout = complete ? c_dout : 32'h0;

    // wait_cnt spans the whole request, including re-misses, so a slow
    // re-fill still counts toward the timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            lat_addr  <= 32'h0;
            lat_din   <= 32'h0;
            lat_rw    <= MEM_RW_READ;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            state <= state_next;
            if (issue_miss) begin
                lat_addr <= addr;
                lat_din  <= din;
                lat_rw   <= req_rw;
                wait_cnt <= '0;
            end else if (state == S_MISS) begin
                if (wait_cnt < WAIT_MAX) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                if (wait_cnt >= WAIT_LAST) begin
                    mem_error <= 1'b1;
                end
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (issue_hit),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (issue_miss),
        .count (miss_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_dcache_access_ctrl.sv
// Directed bench for dcache_access_ctrl with a small behavioural cache model
// (fully associative, 16-byte lines, configurable fill latency).
module tb_dcache_access_ctrl;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        stall;
    logic        mem_error;
    logic        c_is_input_valid;
    logic        c_mem_rw;
    logic [31:0] c_addr;
    logic [31:0] c_din;
    logic        c_is_ready;
    logic        c_is_hit;
    logic [31:0] c_dout;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] stall_cycles;

    int checks;
    int failures;

    dcache_access_ctrl #(.CNT_WIDTH(32), .TIMEOUT(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .addr             (addr),
        .din              (din),
        .dout             (dout),
        .stall            (stall),
        .mem_error        (mem_error),
        .c_is_input_valid (c_is_input_valid),
        .c_mem_rw         (c_mem_rw),
        .c_addr           (c_addr),
        .c_din            (c_din),
        .c_is_ready       (c_is_ready),
        .c_is_hit         (c_is_hit),
        .c_dout           (c_dout),
        .hit_count        (hit_count),
        .miss_count       (miss_count),
        .stall_cycles     (stall_cycles)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cache model
    int          fill_lat;
    bit          hang;
    bit          force_busy;
    int          busy_cnt;
    logic        vld[8];
    logic [27:0] ltag[8];
    logic [2:0]  nxt;
    logic [31:0] mem[1024];
    logic        hit_any;

    assign c_is_ready = !force_busy && (busy_cnt == 0);
    assign c_is_hit   = c_is_ready & hit_any;
    assign c_dout     = mem[c_addr[11:2]];

    always_comb begin
        hit_any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (vld[i] && (ltag[i] == c_addr[31:4])) hit_any = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            busy_cnt <= 0;
            nxt      <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                vld[i]  <= 1'b0;
                ltag[i] <= 28'h0;
            end
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A5_0000 | (i << 2);
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                vld[nxt]  <= 1'b1;
                ltag[nxt] <= c_addr[31:4];
                nxt       <= nxt + 3'd1;
            end
        end else if (c_is_input_valid && c_is_ready) begin
            if (c_is_hit) begin
                if (c_mem_rw) mem[c_addr[11:2]] <= c_din;
            end else begin
                busy_cnt <= hang ? 1000000 : fill_lat - 1;
            end
        end
    end

    // scoreboard helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // driver: call just after a posedge; returns just after a posedge
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, output int stalls, output logic [31:0] data);
        bit done;
        int n;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        din       = d;
        stalls    = 0;
        data      = 32'h0;
        done      = 1'b0;
        n         = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (!stall) begin
                data = dout;
                done = 1'b1;
            end else begin
                stalls++;
                @(posedge clk);
                #1;
            end
            n++;
        end
        chk("access_done", {31'b0, done}, 32'd1);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic pulse_reset();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        int          exp_stalls;
        logic        chk_dout;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          stalls;
        logic [31:0] data;

        checks     = 0;
        failures   = 0;
        fill_lat   = 50;
        hang       = 1'b0;
        force_busy = 1'b0;
        reset      = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr       = 32'h0;
        din        = 32'h0;

        vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        51, 1'b1, 32'hA5A5_0100};
        vecs[1] = '{1'b1, 1'b0, 32'h104, 32'h0,         0, 1'b1, 32'hA5A5_0104};
        vecs[2] = '{1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 51, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h200, 32'h0,         0, 1'b1, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b0, 32'h108, 32'h0,         0, 1'b1, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 32'h104, 32'h55AA55AA,  0, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'h104, 32'h0,         0, 1'b1, 32'h55AA55AA};
        vecs[7] = '{1'b1, 1'b0, 32'h108, 32'h0,         0, 1'b1, 32'hA5A5_0108};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_mem_error", {31'b0, mem_error}, 32'd0);
        chk("rst_valid", {31'b0, c_is_input_valid}, 32'd0);
        chk("rst_dout", dout, 32'h0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            do_access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, stalls, data);
            chk($sformatf("vec%0d_stalls", i), stalls, vecs[i].exp_stalls);
            if (vecs[i].chk_dout) chk($sformatf("vec%0d_dout", i), data, vecs[i].exp_dout);
        end
        chk("tbl_hits", hit_count, 32'd5);
        chk("tbl_misses", miss_count, 32'd2);
        chk("tbl_stall_cycles", stall_cycles, 32'd102);
        chk("tbl_mem_error", {31'b0, mem_error}, 32'd1);

        // cache busy while idle: request held, not issued, then hits
        force_busy = 1'b1;
        mem_read   = 1'b1;
        addr       = 32'h104;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("busy_stall", {31'b0, stall}, 32'd1);
            chk("busy_valid", {31'b0, c_is_input_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        force_busy = 1'b0;
        @(negedge clk);
        chk("busy_release_stall", {31'b0, stall}, 32'd0);
        chk("busy_release_dout", dout, 32'h55AA55AA);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        chk("busy_hits", hit_count, 32'd6);
        chk("busy_misses", miss_count, 32'd2);
        chk("busy_stall_cycles", stall_cycles, 32'd105);

        // pipeline inputs toggle during a store miss; cache sees latched values
        fill_lat  = 6;
        mem_write = 1'b1;
        addr      = 32'h300;
        din       = 32'h12345678;
        stalls    = 0;
        begin
            bit done;
            done = 1'b0;
            for (int n = 0; n < 100 && !done; n++) begin
                @(negedge clk);
                if (!stall) begin
                    done = 1'b1;
                end else begin
                    if (stalls > 0) begin
                        chk("hold_addr", c_addr, 32'h300);
                        chk("hold_din", c_din, 32'h12345678);
                        chk("hold_rw", {31'b0, c_mem_rw}, 32'd1);
                    end
                    stalls++;
                    @(posedge clk);
                    #1;
                    addr = ~addr;
                    din  = ~din;
                end
            end
            chk("hold_done", {31'b0, done}, 32'd1);
        end
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        chk("hold_stalls", stalls, 32'd7);
        do_access(1'b1, 1'b0, 32'h300, 32'h0, stalls, data);
        chk("hold_reload_stalls", stalls, 32'd0);
        chk("hold_reload_dout", data, 32'h12345678);
        chk("hold_hits", hit_count, 32'd7);
        chk("hold_misses", miss_count, 32'd3);
        chk("hold_stall_cycles", stall_cycles, 32'd112);

        // cache never becomes ready: sticky timeout after 16 wait cycles
        pulse_reset();
        hang     = 1'b1;
        mem_read = 1'b1;
        addr     = 32'h500;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            chk($sformatf("to_stall_c%0d", k), {31'b0, stall}, 32'd1);
            chk($sformatf("to_err_c%0d", k), {31'b0, mem_error}, (k >= 17) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end

        // reset in the middle of the outstanding miss
        hang = 1'b0;
        pulse_reset();
        @(negedge clk);
        chk("mrst_stall", {31'b0, stall}, 32'd0);
        chk("mrst_mem_error", {31'b0, mem_error}, 32'd0);
        chk("mrst_valid", {31'b0, c_is_input_valid}, 32'd0);
        chk("mrst_hits", hit_count, 32'd0);
        chk("mrst_misses", miss_count, 32'd0);
        chk("mrst_stall_cycles", stall_cycles, 32'd0);
        @(posedge clk);
        #1;
        fill_lat = 10;
        do_access(1'b1, 1'b0, 32'h100, 32'h0, stalls, data);
        chk("mrst_load_stalls", stalls, 32'd11);
        chk("mrst_load_dout", data, 32'hA5A5_0100);
        chk("mrst_load_misses", miss_count, 32'd1);
        chk("mrst_load_hits", hit_count, 32'd0);
        chk("mrst_load_stall_cycles", stall_cycles, 32'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
